rc_requester: RTL and testbench

- Upstream partner of the reconfiguration sync stage (rc_reqn/rc_ackn handshake).
- Accepts reconfiguration triggers carrying a region/bitstream ID and raises an active-low request, rc_reqn.
- Waits for the one-cycle active-low acknowledge, rc_ackn, then streams a fixed-length bitstream word sequence to the loader.
- One-deep pending slot, ack timeout with sticky error, and a sticky overflow flag.

---
 rtl/rc_pkg.sv | 17 +
 rtl/rc_requester_timeout_cnt.sv | 45 ++++
 rtl/rc_requester.sv | 176 +++++++++++++++++
 tb/tb_rc_requester.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc_pkg.sv
// rc_pkg: shared definitions for the reconfiguration requester.
//   - FSM state encodings (RC_IDLE / RC_REQ / RC_LOAD)
//   - polarity constants for the active-low rc_reqn / rc_ackn handshake
package rc_pkg;

    typedef logic [1:0] rc_state_t;

    localparam rc_state_t RC_IDLE = 2'd0;
    localparam rc_state_t RC_REQ  = 2'd1;
    localparam rc_state_t RC_LOAD = 2'd2;

    // rc_reqn / rc_ackn are both active-low on the wire.
    localparam logic RC_REQ_ON  = 1'b0;
    localparam logic RC_REQ_OFF = 1'b1;
    localparam logic RC_ACK_ON  = 1'b0;

endpackage

// File: rtl/rc_requester_timeout_cnt.sv
// rc_timeout_cnt: clear/enable cycle counter with a terminal-count flag.
// Ports:
//   clk_i  - clock (rising edge)
//   rst_i  - asynchronous active-high reset
//   clr_i  - synchronous clear to zero (wins over en_i)
//   en_i   - count enable
//   tc_o   - high while the count equals TIMEOUT-1
module rc_timeout_cnt
    import rc_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    // Holds at the terminal count so it can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rc_requester.sv
// rc_requester: accepts reconfiguration triggers, requests the sync stage with
// an active-low rc_reqn, waits for the one-cycle rc_ackn pulse and then streams
// LEN bitstream words (index 0..LEN-1) to the loader.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   trig, trig_id       - single-cycle trigger with its region/bitstream ID
//   rc_reqn, rc_ackn    - active-low request (registered) / acknowledge pulse
//   ld_valid, ld_ready  - loader word handshake
//   ld_id, ld_addr      - ID of the bitstream being loaded, word index
//   ld_last             - high with the word at index LEN-1
//   busy                - state is not IDLE
//   err_timeout         - sticky: a request got no ack within TIMEOUT cycles
//   err_overflow        - sticky: a trigger overwrote a full pending slot
//
// Loader handshake: a word moves on every rising edge where ld_valid and
// ld_ready are both high. Once ld_valid is raised it stays high, and ld_id /
// ld_addr / ld_last stay unchanged, until that word has moved; ld_valid never
// depends on ld_ready.
module rc_requester
    import rc_pkg::*;
#(
    parameter int ID_W    = 4,
    parameter int LEN     = 16,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic [ID_W-1:0]   trig_id,
    output logic              rc_reqn,
    input  logic              rc_ackn,
    output logic              ld_valid,
    input  logic              ld_ready,
    output logic [ID_W-1:0]   ld_id,
    output logic [ADDR_W-1:0] ld_addr,
    output logic              ld_last,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEN - 1);

    rc_state_t         state_q, state_d;
    logic              rc_reqn_q, rc_reqn_d;
    logic              ld_valid_q, ld_valid_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [ID_W-1:0]   ld_id_q, ld_id_d;
    logic [ID_W-1:0]   req_id_q, req_id_d;   // ID of the request in flight
    logic              pend_full_q, pend_full_d;
    logic [ID_W-1:0]   pend_id_q, pend_id_d;
    logic              err_to_q, err_to_d;
    logic              err_ov_q, err_ov_d;

    logic ack;
    logic tc;
    logic xfer;
    logic last_word;

    assign ack       = (rc_ackn == RC_ACK_ON);
    assign xfer      = ld_valid_q & ld_ready;
    assign last_word = (ld_addr_q == LAST_ADDR);

    rc_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (state_q != RC_REQ),
        .en_i  (state_q == RC_REQ),
        .tc_o  (tc)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RC_IDLE;
            rc_reqn_q   <= RC_REQ_OFF;
            ld_valid_q  <= 1'b0;
            ld_addr_q   <= '0;
            ld_id_q     <= '0;
            req_id_q    <= '0;
            pend_full_q <= 1'b0;
            pend_id_q   <= '0;
            err_to_q    <= 1'b0;
            err_ov_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            rc_reqn_q   <= rc_reqn_d;
            ld_valid_q  <= ld_valid_d;
            ld_addr_q   <= ld_addr_d;
            ld_id_q     <= ld_id_d;
            req_id_q    <= req_id_d;
            pend_full_q <= pend_full_d;
            pend_id_q   <= pend_id_d;
            err_to_q    <= err_to_d;
            err_ov_q    <= err_ov_d;
        end
    end

    // Next-state logic. An ack in the terminal-count cycle still wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RC_IDLE: if (trig || pend_full_q) state_d = RC_REQ;
            RC_REQ: begin
                if (ack) begin
                    state_d = RC_LOAD;
                end else if (tc) begin
                    state_d = RC_IDLE;
                end
            end
            RC_LOAD: if (xfer && last_word) state_d = RC_IDLE;
            default: state_d = RC_IDLE;
        endcase
    end

    // Registered-output and datapath next values.
    always_comb begin
        // rc_reqn is derived from the next state so it is low exactly in REQ
        // cycles and already high in the cycle after the ack.
        rc_reqn_d   = (state_d == RC_REQ) ? RC_REQ_ON : RC_REQ_OFF;
        ld_valid_d  = (state_d == RC_LOAD);
        ld_addr_d   = ld_addr_q;
        ld_id_d     = ld_id_q;
        req_id_d    = req_id_q;
        pend_full_d = pend_full_q;
        pend_id_d   = pend_id_q;
        err_to_d    = err_to_q;
        err_ov_d    = err_ov_q;

        // Trigger capture: the pending slot is served before a new trigger,
        // and a trigger arriving in that same cycle refills the slot.
        if (state_q == RC_IDLE) begin
            if (pend_full_q) begin
                req_id_d    = pend_id_q;
                pend_full_d = trig;
                if (trig) pend_id_d = trig_id;
            end else if (trig) begin
                req_id_d = trig_id;
            end
        end else if (trig) begin
            pend_id_d   = trig_id;
            pend_full_d = 1'b1;
            if (pend_full_q) err_ov_d = 1'b1;
        end

        if (state_q == RC_REQ) begin
            if (ack) begin
                ld_id_d   = req_id_q;
                ld_addr_d = '0;
            end else if (tc) begin
                err_to_d = 1'b1;
            end
        end

        // Index returns to 0 after the last word so it never leaves 0..LEN-1.
        if (state_q == RC_LOAD && xfer) begin
            ld_addr_d = last_word ? '0 : ld_addr_q + 1'b1;
        end
    end

    // Outputs.
    always_comb begin
        rc_reqn      = rc_reqn_q;
        ld_valid     = ld_valid_q;
        ld_addr      = ld_addr_q;
        ld_id        = ld_id_q;
        ld_last      = ld_valid_q & last_word;
        busy         = (state_q != RC_IDLE);
        err_timeout  = err_to_q;
        err_overflow = err_ov_q;
    end

endmodule

// File: tb/tb_rc_requester.sv
module tb_rc_requester;

    localparam int ID_W    = 4;
    localparam int LEN     = 16;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 8;
    localparam int W       = ID_W + ADDR_W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              trig = 1'b0;
    logic [ID_W-1:0]   trig_id = '0;
    logic              rc_ackn = 1'b1;
    logic              ld_ready = 1'b0;
    logic              rc_reqn, ld_valid, ld_last, busy, err_timeout, err_overflow;
    logic [ID_W-1:0]   ld_id;
    logic [ADDR_W-1:0] ld_addr;

    rc_requester #(
        .ID_W    (ID_W),
        .LEN     (LEN),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trig         (trig),
        .trig_id      (trig_id),
        .rc_reqn      (rc_reqn),
        .rc_ackn      (rc_ackn),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_id        (ld_id),
        .ld_addr      (ld_addr),
        .ld_last      (ld_last),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_overflow (err_overflow)
    );

    int n_checks = 0;
    int n_err    = 0;
    int xfer_cnt = 0;
    bit mon_en   = 1'b0;
    logic [W-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rc_reqn"},      32'(rc_reqn), 1);
        check({tag, "_ld_valid"},     32'(ld_valid), 0);
        check({tag, "_ld_last"},      32'(ld_last), 0);
        check({tag, "_ld_addr"},      32'(ld_addr), 0);
        check({tag, "_ld_id"},        32'(ld_id), 0);
        check({tag, "_busy"},         32'(busy), 0);
        check({tag, "_err_timeout"},  32'(err_timeout), 0);
        check({tag, "_err_overflow"}, 32'(err_overflow), 0);
    endtask

    task automatic push_words(input logic [ID_W-1:0] id);
        for (int a = 0; a < LEN; a++) begin
            exp_q.push_back({id, ADDR_W'(a), (a == LEN - 1)});
        end
    endtask

    // Trigger, wait `delay` REQ cycles, then pulse the ack in REQ cycle `delay`.
    task automatic do_req(input logic [ID_W-1:0] id, input int delay, input string tag);
        trig = 1'b1;
        trig_id = id;
        tick();
        trig = 1'b0;
        check({tag, "_req_low"}, 32'(rc_reqn), 0);
        check({tag, "_req_busy"}, 32'(busy), 1);
        repeat (delay) tick();
        rc_ackn = 1'b0;
        tick();
        rc_ackn = 1'b1;
        check({tag, "_req_release"}, 32'(rc_reqn), 1);
        check({tag, "_load_valid"}, 32'(ld_valid), 1);
        check({tag, "_load_id"}, 32'(ld_id), 32'(id));
        check({tag, "_load_addr0"}, 32'(ld_addr), 0);
    endtask

    // Drive ld_ready (constant 1, or the 1,0,0,1 pattern) until the load ends.
    task automatic run_load(input bit bp, input string tag);
        int i = 0;
        while (busy && i < 400) begin
            ld_ready = bp ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
            tick();
            i++;
        end
        ld_ready = 1'b1;
        check({tag, "_load_done"}, 32'(busy), 0);
        check({tag, "_words_left"}, 32'(exp_q.size()), 0);
    endtask

    // ---------------- scoreboard ----------------
    // Every valid word must match the head of exp_q (so it also holds steady
    // while stalled); the head retires when the word is accepted.
    always @(negedge clk) begin
        if (!rst && mon_en && ld_valid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL word_unexpected: got id=%0d addr=%0d last=%0b, expected no valid word",
                         ld_id, ld_addr, ld_last);
            end else begin
                if ({ld_id, ld_addr, ld_last} !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL word: got id=%0d addr=%0d last=%0b, expected id=%0d addr=%0d last=%0b",
                             ld_id, ld_addr, ld_last, exp_q[0][W-1 -: ID_W],
                             exp_q[0][ADDR_W:1], exp_q[0][0]);
                end
                if (ld_ready) begin
                    void'(exp_q.pop_front());
                    xfer_cnt++;
                end
            end
        end
    end

    // ---------------- basic vector table ----------------
    typedef struct {
        logic              trig;
        logic [ID_W-1:0]   tid;
        logic              ackn;
        logic              ready;
        logic              reqn;
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic              last;
        logic [ID_W-1:0]   id;
        logic              busy;
    } vec_t;

    function automatic vec_t mk(logic t, logic [ID_W-1:0] tid, logic ackn, logic rdy,
                                logic reqn, logic vld, logic [ADDR_W-1:0] addr,
                                logic last, logic [ID_W-1:0] id, logic bsy);
        vec_t v;
        v.trig = t; v.tid = tid; v.ackn = ackn; v.ready = rdy;
        v.reqn = reqn; v.valid = vld; v.addr = addr; v.last = last; v.id = id; v.busy = bsy;
        return v;
    endfunction

    vec_t tbl[20];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Trig ID 3, ack seen in the third REQ cycle, then 16 words with ready=1.
        tbl[0] = mk(1'b1, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b1);
        tbl[1] = mk(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b1);
        tbl[2] = mk(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 1'b1);
        tbl[3] = mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 4'd3, 1'b1);
        for (int k = 1; k < 16; k++) begin
            tbl[3 + k] = mk(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 8'(k), (k == 15), 4'd3, 1'b1);
        end
        tbl[19] = mk(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 4'd3, 1'b0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("in_reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_reset_outputs("after_reset");

        // Basic request/load, table driven.
        for (int i = 0; i < 20; i++) begin
            trig     = tbl[i].trig;
            trig_id  = tbl[i].tid;
            rc_ackn  = tbl[i].ackn;
            ld_ready = tbl[i].ready;
            tick();
            check($sformatf("basic[%0d] {reqn,valid,addr,last,id,busy}", i),
                  32'({rc_reqn, ld_valid, ld_addr, ld_last, ld_id, busy}),
                  32'({tbl[i].reqn, tbl[i].valid, tbl[i].addr, tbl[i].last, tbl[i].id, tbl[i].busy}));
        end
        trig = 1'b0;
        rc_ackn = 1'b1;
        mon_en = 1'b1;

        // Backpressure: ready pattern 1,0,0,1.
        ld_ready = 1'b0;
        xfer_cnt = 0;
        push_words(4'd9);
        do_req(4'd9, 0, "bp");
        run_load(1'b1, "bp");
        check("bp_xfer_count", 32'(xfer_cnt), LEN);

        // Ack in the terminal-count cycle: ack wins.
        push_words(4'd7);
        do_req(4'd7, TIMEOUT - 1, "simul");
        check("simul_no_timeout", 32'(err_timeout), 0);
        run_load(1'b0, "simul");
        check("simul_no_timeout_end", 32'(err_timeout), 0);

        // Pending slot and overflow: trigs 5 then 6 during the load of ID 1.
        push_words(4'd1);
        do_req(4'd1, 1, "pend");
        ld_ready = 1'b1;
        tick();
        tick();
        trig = 1'b1; trig_id = 4'd5;
        tick();
        trig = 1'b0;
        check("pend_first_no_overflow", 32'(err_overflow), 0);
        tick();
        trig = 1'b1; trig_id = 4'd6;
        tick();
        trig = 1'b0;
        check("pend_overflow", 32'(err_overflow), 1);
        check("pend_still_loading", 32'(busy), 1);
        run_load(1'b0, "pend_id1");
        push_words(4'd6);
        tick();
        check("pend_auto_req", 32'(rc_reqn), 0);
        check("pend_ld_id_holds", 32'(ld_id), 1);
        rc_ackn = 1'b0;
        tick();
        rc_ackn = 1'b1;
        check("pend_load_id6", 32'(ld_id), 6);
        run_load(1'b0, "pend_id6");
        tick();
        check("pend_slot_empty", 32'(busy), 0);

        // Timeout: no ack for TIMEOUT REQ cycles, then a stale ack.
        trig = 1'b1; trig_id = 4'd2;
        tick();
        trig = 1'b0;
        check("to_req_low", 32'(rc_reqn), 0);
        repeat (TIMEOUT - 1) tick();
        check("to_last_req_cycle", 32'(rc_reqn), 0);
        check("to_not_yet", 32'(err_timeout), 0);
        tick();
        check("to_req_high", 32'(rc_reqn), 1);
        check("to_err", 32'(err_timeout), 1);
        check("to_idle", 32'(busy), 0);
        tick();
        tick();
        rc_ackn = 1'b0;
        tick();
        rc_ackn = 1'b1;
        repeat (3) tick();
        check("to_stale_ack_valid", 32'(ld_valid), 0);
        check("to_stale_ack_busy", 32'(busy), 0);
        check("to_err_sticky", 32'(err_timeout), 1);

        // Reset at word 7 of a load with a trigger pending.
        push_words(4'd4);
        do_req(4'd4, 0, "rst");
        ld_ready = 1'b1;
        tick();
        trig = 1'b1; trig_id = 4'd8;
        tick();
        trig = 1'b0;
        repeat (5) tick();
        check("rst_at_word7", 32'(ld_addr), 7);
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        tick();
        tick();
        check("rst_pending_cleared_busy", 32'(busy), 0);
        check("rst_pending_cleared_reqn", 32'(rc_reqn), 1);
        mon_en = 1'b1;
        push_words(4'hA);
        do_req(4'hA, 1, "fresh");
        run_load(1'b0, "fresh");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
